// File: rtl/lane_mask_serializer_if.sv
// Handshake bundle for lane_mask_serializer: mask input channel and lane-index output channel.
// The slave modport is the serializer's view; master is the producer/consumer side.
interface lane_mask_serializer_if #(
  parameter int unsigned WIDTH = 32
) ();
  localparam int unsigned IDXW   = $clog2(WIDTH);
  localparam int unsigned CWIDTH = $clog2(WIDTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_mask;
  logic              out_valid;
  logic              out_ready;
  logic [IDXW-1:0]   out_idx;
  logic              out_last;
  logic [CWIDTH-1:0] out_remaining;

  modport slave (
    input  in_valid,
    input  in_mask,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_idx,
    output out_last,
    output out_remaining
  );

  modport master (
    output in_valid,
    output in_mask,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_idx,
    input  out_last,
    input  out_remaining
  );
endinterface

// File: rtl/lane_mask_serializer.sv
// Accepts an active-lane mask and emits the index of each set lane, lowest first,
// one per output beat, with the remaining-lane count and a last flag.
module lane_mask_serializer #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned IDXW   = $clog2(WIDTH),
  parameter int unsigned CWIDTH = $clog2(WIDTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  lane_mask_serializer_if.slave  bus,
  output logic                   busy_o
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StEmit = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [WIDTH-1:0]  mask_q, mask_d;

  logic [IDXW-1:0]   low_idx;
  logic [CWIDTH-1:0] pop_cnt;
  logic              is_last;
  logic              emitting;
  logic              in_xfer;
  logic              out_xfer;

  // Scan downwards so the final assignment wins with the lowest set index.
  always_comb begin
    low_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        low_idx = IDXW'(i);
      end
    end
  end

  // CWIDTH is one bit wider than an index, so an all-ones mask counts to WIDTH.
  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop_cnt = pop_cnt + CWIDTH'(mask_q[i]);
    end
  end

  assign emitting = (state_q == StEmit);
  assign is_last  = emitting && (pop_cnt == CWIDTH'(1));

  assign bus.out_valid     = emitting;
  assign bus.out_idx       = emitting ? low_idx : '0;
  assign bus.out_remaining = emitting ? pop_cnt : '0;
  assign bus.out_last      = is_last;
  assign busy_o            = emitting;

  // Accept a new mask while idle, or in the same cycle the final beat leaves.
  assign bus.in_ready = emitting ? (bus.out_ready && is_last) : 1'b1;

  assign in_xfer  = bus.in_valid && bus.in_ready;
  assign out_xfer = bus.out_valid && bus.out_ready;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    case (state_q)
      StIdle: begin
        if (in_xfer && (bus.in_mask != '0)) begin
          mask_d  = bus.in_mask;
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (out_xfer) begin
          if (!is_last) begin
            // Clears exactly the lowest set bit, i.e. the lane just emitted.
            mask_d = mask_q & (mask_q - WIDTH'(1));
          end else if (in_xfer && (bus.in_mask != '0)) begin
            mask_d = bus.in_mask;
          end else begin
            mask_d  = '0;
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
        mask_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
    end
  end

endmodule
